// File: rtl/led_scanner_pkg.sv
// ---------------------------------------------------------------------------
// led_scanner_pkg : shared constants for the LED scanner and its helpers
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package led_scanner_pkg;

  localparam logic [1:0] MODE_BOUNCE    = 2'd0;
  localparam logic [1:0] MODE_WRAP_UP   = 2'd1;
  localparam logic [1:0] MODE_WRAP_DOWN = 2'd2;
  localparam logic [1:0] MODE_FILL      = 2'd3;

  localparam logic [0:0] DIR_UP   = 1'b0;
  localparam logic [0:0] DIR_DOWN = 1'b1;

  // Trail LED is lit while the 2-bit PWM count is below its limit
  localparam logic [1:0] PWM_TRAIL1_LIMIT = 2'd2;
  localparam logic [1:0] PWM_TRAIL2_LIMIT = 2'd1;

endpackage

`default_nettype wire

// File: rtl/led_prescaler.sv
// ---------------------------------------------------------------------------
// led_prescaler : enable-gated step-period counter producing a one-cycle tick
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module led_prescaler #(
  parameter int PRESCALE_W = 24
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [PRESCALE_W-1:0] i_period,
  output logic                  o_tick
);

  logic [PRESCALE_W-1:0] count_q, count_d;

  // >= so that shrinking i_period mid-count ticks immediately
  always_comb begin
    o_tick  = i_enable && (count_q >= i_period);
    count_d = count_q;
    if (i_enable) begin
      count_d = o_tick ? '0 : count_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_scanner.sv
// ---------------------------------------------------------------------------
// led_scanner : parametrised multi-pattern LED scanner (BOUNCE/WRAP/FILL)
// Optional macro LED_SCANNER_TAIL_EN adds PWM-dimmed trailing LEDs.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module led_scanner
  import led_scanner_pkg::*;
#(
  parameter int N_LEDS     = 8,
  parameter int PRESCALE_W = 24,
  parameter int POS_W      = $clog2(N_LEDS)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [1:0]            i_mode,
  input  logic [PRESCALE_W-1:0] i_period,
  output logic [N_LEDS-1:0]     o_led,
  output logic [POS_W-1:0]      o_pos,
  output logic                  o_dir,
  output logic                  o_wrap
);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(N_LEDS - 1);
  localparam logic [POS_W-1:0] ONE      = POS_W'(1);

  logic              tick;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [0:0]        dir_q, dir_d;
  logic              wrap_q, wrap_d;
  logic [1:0]        mode_q, mode_d;
  logic [N_LEDS-1:0] led_q, led_d;

  led_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_enable(i_enable),
    .i_period(i_period),
    .o_tick  (tick)
  );

  // Mode is sampled on each tick and applied to that tick's step
  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    wrap_d = 1'b0;
    if (tick) begin
      mode_d = i_mode;
      case (i_mode)
        MODE_BOUNCE: begin
          if (dir_q == DIR_UP) begin
            if (pos_q == LAST_POS) begin
              pos_d = pos_q - ONE;
              dir_d = DIR_DOWN;
            end else begin
              pos_d = pos_q + ONE;
            end
          end else begin
            if (pos_q == '0) begin
              pos_d = ONE;
              dir_d = DIR_UP;
            end else begin
              pos_d = pos_q - ONE;
            end
          end
        end
        MODE_WRAP_DOWN: begin
          pos_d = (pos_q == '0) ? LAST_POS : pos_q - ONE;
          dir_d = DIR_DOWN;
        end
        default: begin
          pos_d = (pos_q == LAST_POS) ? '0 : pos_q + ONE;
          dir_d = DIR_UP;
        end
      endcase
      wrap_d = (i_mode == MODE_WRAP_DOWN) ? (pos_d == LAST_POS) : (pos_d == '0);
    end
  end

`ifdef LED_SCANNER_TAIL_EN
  logic [1:0] pwm_q, pwm_d;

  assign pwm_d = pwm_q + 2'd1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pwm_q <= 2'd0;
    end else begin
      pwm_q <= pwm_d;
    end
  end
`endif

  always_comb begin
    led_d = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      if (mode_q == MODE_FILL) begin
        led_d[i] = (i <= int'(pos_q));
      end else begin
        led_d[i] = (i == int'(pos_q));
      end
    end
`ifdef LED_SCANNER_TAIL_EN
    // Trail sits behind the head; BOUNCE drops off-strip trails, WRAP_* wraps them
    if (mode_q != MODE_FILL) begin
      int step;
      int trail1;
      int trail2;
      step   = (dir_q == DIR_UP) ? -1 : 1;
      trail1 = int'(pos_q) + step;
      trail2 = int'(pos_q) + 2 * step;
      if (mode_q != MODE_BOUNCE) begin
        if (trail1 < 0)       trail1 = trail1 + N_LEDS;
        if (trail1 >= N_LEDS) trail1 = trail1 - N_LEDS;
        if (trail2 < 0)       trail2 = trail2 + N_LEDS;
        if (trail2 >= N_LEDS) trail2 = trail2 - N_LEDS;
      end
      for (int i = 0; i < N_LEDS; i++) begin
        if (i == trail1 && pwm_q < PWM_TRAIL1_LIMIT) led_d[i] = 1'b1;
        if (i == trail2 && pwm_q < PWM_TRAIL2_LIMIT) led_d[i] = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pos_q  <= '0;
      dir_q  <= DIR_UP;
      wrap_q <= 1'b0;
      mode_q <= MODE_BOUNCE;
      led_q  <= '0;
    end else begin
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      wrap_q <= wrap_d;
      mode_q <= mode_d;
      led_q  <= led_d;
    end
  end

  assign o_led  = led_q;
  assign o_pos  = pos_q;
  assign o_dir  = dir_q;
  assign o_wrap = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_led_scanner.sv
// ---------------------------------------------------------------------------
// tb_led_scanner : directed, table-driven bench for led_scanner (N_LEDS=8)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_led_scanner;
  import led_scanner_pkg::*;

  localparam int N   = 8;
  localparam int PW  = 24;
  localparam int PSW = 3;

  typedef struct {
    logic       rst_before;
    logic [1:0] mode;
    logic [2:0] pos;
    logic       dir;
    logic       wrap;
    logic [7:0] led;
  } vec_t;

  logic          i_clk    = 1'b0;
  logic          i_reset  = 1'b0;
  logic          i_enable = 1'b0;
  logic [1:0]    i_mode   = 2'd0;
  logic [PW-1:0] i_period = '0;
  logic [N-1:0]  o_led;
  logic [PSW-1:0] o_pos;
  logic          o_dir;
  logic          o_wrap;

  int checks = 0;
  int errors = 0;
  vec_t vq[$];

  always #5 i_clk = ~i_clk;

  led_scanner #(
    .N_LEDS    (N),
    .PRESCALE_W(PW)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_enable(i_enable),
    .i_mode  (i_mode),
    .i_period(i_period),
    .o_led   (o_led),
    .o_pos   (o_pos),
    .o_dir   (o_dir),
    .o_wrap  (o_wrap)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Head-only view when trailing LEDs are built in
  function automatic logic [31:0] led_view(input logic [7:0] l, input logic [7:0] exp);
`ifdef LED_SCANNER_TAIL_EN
    return 32'(l & exp);
`else
    return 32'(l | (exp & 8'h00));
`endif
  endfunction

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic do_reset(input logic [1:0] mode, input logic [PW-1:0] per);
    @(negedge i_clk);
    i_reset  = 1'b1;
    i_enable = 1'b1;
    i_mode   = mode;
    i_period = per;
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  task automatic add(input logic r, input logic [1:0] m, input logic [2:0] p,
                     input logic d, input logic w, input logic [7:0] l);
    vec_t v;
    v.rst_before = r; v.mode = m; v.pos = p; v.dir = d; v.wrap = w; v.led = l;
    vq.push_back(v);
  endtask

  initial begin
    logic [2:0] prev;
    logic [2:0] exp_pos;
    int n2;
    int n3;

    // BOUNCE, period 0: one full 14-tick cycle plus two extra steps
    add(1, MODE_BOUNCE, 3'd1, 0, 0, 8'h01);
    add(0, MODE_BOUNCE, 3'd2, 0, 0, 8'h02);
    add(0, MODE_BOUNCE, 3'd3, 0, 0, 8'h04);
    add(0, MODE_BOUNCE, 3'd4, 0, 0, 8'h08);
    add(0, MODE_BOUNCE, 3'd5, 0, 0, 8'h10);
    add(0, MODE_BOUNCE, 3'd6, 0, 0, 8'h20);
    add(0, MODE_BOUNCE, 3'd7, 0, 0, 8'h40);
    add(0, MODE_BOUNCE, 3'd6, 1, 0, 8'h80);
    add(0, MODE_BOUNCE, 3'd5, 1, 0, 8'h40);
    add(0, MODE_BOUNCE, 3'd4, 1, 0, 8'h20);
    add(0, MODE_BOUNCE, 3'd3, 1, 0, 8'h10);
    add(0, MODE_BOUNCE, 3'd2, 1, 0, 8'h08);
    add(0, MODE_BOUNCE, 3'd1, 1, 0, 8'h04);
    add(0, MODE_BOUNCE, 3'd0, 1, 1, 8'h02);
    add(0, MODE_BOUNCE, 3'd1, 0, 0, 8'h01);
    add(0, MODE_BOUNCE, 3'd2, 0, 0, 8'h02);
    // FILL, period 0
    add(1, MODE_FILL, 3'd1, 0, 0, 8'h01);
    add(0, MODE_FILL, 3'd2, 0, 0, 8'h03);
    add(0, MODE_FILL, 3'd3, 0, 0, 8'h07);
    add(0, MODE_FILL, 3'd4, 0, 0, 8'h0F);
    add(0, MODE_FILL, 3'd5, 0, 0, 8'h1F);
    add(0, MODE_FILL, 3'd6, 0, 0, 8'h3F);
    add(0, MODE_FILL, 3'd7, 0, 0, 8'h7F);
    add(0, MODE_FILL, 3'd0, 0, 1, 8'hFF);
    add(0, MODE_FILL, 3'd1, 0, 0, 8'h01);
    add(0, MODE_FILL, 3'd2, 0, 0, 8'h03);

    // Reset state, asynchronously applied between clock edges
    #2 i_reset = 1'b1;
    #1;
    check("rst_led",  32'(o_led),  32'h0);
    check("rst_pos",  32'(o_pos),  32'h0);
    check("rst_dir",  32'(o_dir),  32'h0);
    check("rst_wrap", 32'(o_wrap), 32'h0);

    foreach (vq[k]) begin
      if (vq[k].rst_before) do_reset(vq[k].mode, '0);
      else i_mode = vq[k].mode;
      step();
      check($sformatf("tbl%0d_pos", k),  32'(o_pos),  32'(vq[k].pos));
      check($sformatf("tbl%0d_dir", k),  32'(o_dir),  32'(vq[k].dir));
      check($sformatf("tbl%0d_wrap", k), 32'(o_wrap), 32'(vq[k].wrap));
      if (vq[k].mode == MODE_FILL)
        check($sformatf("tbl%0d_led", k), 32'(o_led), 32'(vq[k].led));
      else
        check($sformatf("tbl%0d_led", k), led_view(o_led, vq[k].led), 32'(vq[k].led));
    end

    // WRAP_UP, period 3: one step every 4 cycles
    do_reset(MODE_WRAP_UP, 24'd3);
    prev = 3'd0;
    for (int e = 1; e <= 33; e++) begin
      step();
      exp_pos = 3'((e / 4) % 8);
      check($sformatf("wu%0d_pos", e), 32'(o_pos), 32'(exp_pos));
      check($sformatf("wu%0d_led", e), led_view(o_led, 8'h01 << prev), 32'(8'h01 << prev));
      check($sformatf("wu%0d_wrap", e), 32'(o_wrap), 32'((e % 4 == 0) && (exp_pos == 3'd0)));
      check($sformatf("wu%0d_dir", e), 32'(o_dir), 32'h0);
      prev = exp_pos;
    end

    // WRAP_DOWN from reset
    do_reset(MODE_WRAP_DOWN, '0);
    step();
    check("wd1_pos",  32'(o_pos),  32'd7);
    check("wd1_wrap", 32'(o_wrap), 32'h1);
    check("wd1_dir",  32'(o_dir),  32'h1);
    step();
    check("wd2_pos",  32'(o_pos),  32'd6);
    check("wd2_wrap", 32'(o_wrap), 32'h0);
    check("wd2_led",  led_view(o_led, 8'h80), 32'h80);
    step();
    check("wd3_led",  led_view(o_led, 8'h40), 32'h40);

    // Pause at pos 5, then resume after period+1 enabled cycles
    do_reset(MODE_WRAP_UP, 24'd2);
    for (int k = 0; k < 100 && o_pos != 3'd5; k++) step();
    check("pause_reach", 32'(o_pos), 32'd5);
    i_enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      check($sformatf("pause%0d_led", k), led_view(o_led, 8'h20), 32'h20);
      check($sformatf("pause%0d_pos", k), 32'(o_pos), 32'd5);
      check($sformatf("pause%0d_wrap", k), 32'(o_wrap), 32'h0);
    end
    i_enable = 1'b1;
    step();
    check("resume1_pos", 32'(o_pos), 32'd5);
    step();
    check("resume2_pos", 32'(o_pos), 32'd5);
    step();
    check("resume3_pos", 32'(o_pos), 32'd6);

    // Async reset while BOUNCE is moving down at pos 4
    do_reset(MODE_BOUNCE, '0);
    repeat (10) step();
    check("mid_pos", 32'(o_pos), 32'd4);
    check("mid_dir", 32'(o_dir), 32'h1);
    #2 i_reset = 1'b1;
    #1;
    check("async_led", 32'(o_led), 32'h0);
    check("async_pos", 32'(o_pos), 32'h0);
    check("async_dir", 32'(o_dir), 32'h0);
    #1 i_reset = 1'b0;
    step();
    check("post_rst_pos", 32'(o_pos), 32'd1);
    check("post_rst_dir", 32'(o_dir), 32'h0);
    check("post_rst_led", led_view(o_led, 8'h01), 32'h01);

    // Switch BOUNCE to WRAP_UP while moving down at pos 4
    repeat (9) step();
    check("sw_pre_pos", 32'(o_pos), 32'd4);
    check("sw_pre_dir", 32'(o_dir), 32'h1);
    i_mode = MODE_WRAP_UP;
    step();
    check("sw_pos", 32'(o_pos), 32'd5);
    check("sw_dir", 32'(o_dir), 32'h0);

`ifdef LED_SCANNER_TAIL_EN
    // BOUNCE up at pos 4: trail-1 at 50%, trail-2 at 25% over a PWM frame
    do_reset(MODE_BOUNCE, '0);
    repeat (4) step();
    check("tail_pos", 32'(o_pos), 32'd4);
    i_enable = 1'b0;
    n2 = 0;
    n3 = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      n3 += int'(o_led[3]);
      n2 += int'(o_led[2]);
      check($sformatf("tail%0d_head", k), 32'(o_led & 8'hF0), 32'h10);
    end
    check("tail_trail1_count", 32'(n3), 32'd2);
    check("tail_trail2_count", 32'(n2), 32'd1);
`else
    n2 = 0;
    n3 = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_scanner.md
Name: led_scanner

Overview:
Parametrised LED scanner for board status and demo displays; successor to the fixed 8-LED KITT sweep.
- Generalises LED count and step rate.
- Adds four run-time selectable patterns, an enable/pause input and a sweep-complete pulse.
- Sits between top-level clock/reset and the board LED pins; driven by the system clock, with no external tick source.

Parameters:
N_LEDS, 8, number of LEDs driven; legal range 2..32
PRESCALE_W, 24, width of the step-period counter and of i_period
POS_W, $clog2(N_LEDS), width of the position index (derived, not overridden)

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_enable  in  1  1 = run, 0 = pause (prescaler and position hold)
i_mode  in  2  0 BOUNCE, 1 WRAP_UP, 2 WRAP_DOWN, 3 FILL
i_period  in  PRESCALE_W  step period minus one, in i_clk cycles
o_led  out  N_LEDS  LED drive, registered
o_pos  out  POS_W  current position index
o_dir  out  1  0 = up, 1 = down
o_wrap  out  1  one-cycle pulse when the sequence returns to its start position

Behaviour:
- Reset: asynchronous, active-high on i_reset; clock i_clk.
  - All outputs reset to 0; prescaler count = 0; direction = up.
- Prescaler:
  - While i_enable=1, count increments each cycle.
  - tick = (count >= i_period); on tick, count returns to 0. The >= compare makes a mid-count reduction of i_period take effect at once.
  - i_period=0 gives a tick every cycle.
  - While i_enable=0, count, position and direction hold; o_wrap=0.
- Position update on tick:
  - BOUNCE: up until N_LEDS-1, then down until 0, then up. Full period is 2*N_LEDS-2 ticks. Each end position is visited once per turn.
  - WRAP_UP: pos+1; N_LEDS-1 wraps to 0. o_dir forced 0.
  - WRAP_DOWN: pos-1; 0 wraps to N_LEDS-1. o_dir forced 1.
  - FILL: same position sequence as WRAP_UP.
- Mode change:
  - Sampled on every tick; the new mode's rule applies to that tick's update, starting from the current pos.
  - BOUNCE entered with dir=1 continues downward.
  - Out-of-range pos cannot occur, since all modes keep pos within 0..N_LEDS-1.
- o_wrap: asserted for one cycle, coincident with the registered pos update, when:
  - BOUNCE/WRAP_UP/FILL: new pos = 0.
  - WRAP_DOWN: new pos = N_LEDS-1.
- o_led decode, registered one cycle after pos:
  - BOUNCE/WRAP_*: one-hot (1 << pos).
  - FILL: bits 0..pos set.
- Latency:
  - First tick after reset release occurs i_period+1 enabled cycles later.
  - o_led shows pos 0 (one-hot 0x01) from the first clock edge after reset release.
- Reset mid-operation: outputs clear immediately (asynchronous); the sequence restarts from pos 0, dir up.

Optional Feature:
LED_SCANNER_TAIL_EN
- Defined:
  - A free-running 2-bit PWM counter (enabled regardless of i_enable) dims the two LEDs trailing the head in BOUNCE and WRAP_* modes.
    - Trail-1 is lit when pwm<2 (50% duty).
    - Trail-2 is lit when pwm==0 (25% duty).
  - Trailing is opposite to the direction of travel.
  - BOUNCE: trail positions beyond 0 or N_LEDS-1 are dropped.
  - WRAP_*: trail positions wrap modulo N_LEDS.
  - FILL is unaffected.
  - The PWM counter resets to 0.
- Undefined: o_led is strictly the decode above; no PWM logic is present.

Decomposition:
- Package led_scanner_pkg holds:
  - mode constants MODE_BOUNCE/MODE_WRAP_UP/MODE_WRAP_DOWN/MODE_FILL (2-bit);
  - DIR_UP/DIR_DOWN;
  - the PWM duty thresholds.
- Sub-module led_prescaler (PRESCALE_W): enable, period in; tick out. It is reused by other timed blocks.
- Position/direction FSM and LED decode stay in led_scanner.

Test Plan:
- N_LEDS=8, period=0, BOUNCE, enable=1 -> o_led 01,02,04,...,80,40,...,02,01 on consecutive cycles; o_wrap pulses every 14 cycles at pos 0.
- period=3, WRAP_UP -> pos advances every 4 cycles; 0x80 followed by 0x01 with o_wrap=1; o_dir=0 throughout.
- WRAP_DOWN from reset -> first tick gives pos 7, o_led=0x80, o_wrap=1, o_dir=1; then 0x40, 0x20 and so on.
- FILL, period=0 -> o_led 0x01,0x03,0x07,...,0xFF,0x01; pos 3 gives 0x0F.
- Pause at pos 5 with enable=0 for 20 cycles -> o_led holds 0x20 and o_wrap=0; re-enable resumes at pos 6 after i_period+1 cycles. Assert i_reset mid-sweep -> o_led=0 with no clock edge; after release, pos 0 and dir up.
- Switch BOUNCE to WRAP_UP while moving down at pos 4 -> next tick gives pos 5 and o_dir=0. With TAIL_EN, BOUNCE up at pos 4 -> bit3 lit 50% and bit2 lit 25% over the 4-cycle PWM frame.
